// File: rtl/ecc_secded_pipe.sv
// ---------------------------------------------------------------------------
// ecc_secded_pipe
// Pipelined SECDED (extended Hamming) checker/corrector for RAM/FIFO read
// paths, plus a combinational encoder that shares the same H-matrix.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   enc_data  / enc_parity     combinational encoder (write side)
//   in_valid/in_ready          input handshake
//   in_data, in_parity         stored word and its stored check bits
//   in_bypass                  pass the beat through unchecked
//   out_valid/out_ready        output handshake
//   out_data                   corrected data
//   out_syndrome               {overall mismatch, Hamming syndrome}
//   out_sbit_err/out_dbit_err  correctable / uncorrectable classification
//   clr_cnt                    synchronous clear of counters and capture
//   cnt_sbit, cnt_dbit         saturating error counters
//   first_err_vld/_syn         syndrome of the first erroring beat
// ---------------------------------------------------------------------------
module ecc_secded_pipe #(
   parameter int DATA_WIDTH   = 13,
   // r+1, where r is the smallest value with 2^r >= DATA_WIDTH+r+1.
   parameter int PARITY_WIDTH = (DATA_WIDTH <= 4)  ? 4 :
                                (DATA_WIDTH <= 11) ? 5 :
                                (DATA_WIDTH <= 26) ? 6 :
                                (DATA_WIDTH <= 57) ? 7 : 8,
   parameter int PIPE_STAGES  = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   enc_data,
   output logic [PARITY_WIDTH-1:0] enc_parity,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [PARITY_WIDTH-1:0] in_parity,
   input  logic                    in_bypass,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [PARITY_WIDTH-1:0] out_syndrome,
   output logic                    out_sbit_err,
   output logic                    out_dbit_err,
   input  logic                    clr_cnt,
   output logic [CNT_WIDTH-1:0]    cnt_sbit,
   output logic [CNT_WIDTH-1:0]    cnt_dbit,
   output logic                    first_err_vld,
   output logic [PARITY_WIDTH-1:0] first_err_syn
);

   localparam int R = PARITY_WIDTH - 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  sbit;
      logic                  dbit;
   } dec_t;

   // Column of data bit idx: the idx-th integer >= 3 that is not a power of two.
   function automatic int unsigned col_of(input int unsigned idx);
      int unsigned n;
      col_of = 0;
      n      = 0;
      for (int unsigned c = 3; c < 128; c++) begin
         if ((c & (c - 1)) != 0) begin
            if (n == idx) col_of = c;
            n++;
         end
      end
   endfunction

   function automatic logic [PARITY_WIDTH-1:0] calc_parity(input logic [DATA_WIDTH-1:0] d);
      logic [PARITY_WIDTH-1:0] p;
      int unsigned             c;
      p = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         c = col_of(i);
         for (int k = 0; k < R; k++)
            if (c[k]) p[k] = p[k] ^ d[i];
      end
      // Overall bit covers the data and the freshly computed Hamming bits.
      p[R] = (^d) ^ (^p[R-1:0]);
      return p;
   endfunction

   function automatic dec_t decode(input logic [DATA_WIDTH-1:0] d,
                                   input logic [PARITY_WIDTH-1:0] s);
      dec_t         res;
      logic [R-1:0] l;
      logic         hit;
      l        = s[R-1:0];
      res.data = d;
      res.sbit = 1'b0;
      res.dbit = 1'b0;
      hit      = 1'b0;
      if (s[R]) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (col_of(i) == 32'(l)) begin
               res.data[i] = ~d[i];
               hit         = 1'b1;
            end
         end
         // No matching column: zero or power-of-two points at a check bit.
         if (hit || ((l & (l - R'(1))) == '0)) res.sbit = 1'b1;
         else                                    res.dbit = 1'b1;
      end else if (l != '0) begin
         res.dbit = 1'b1;
      end
      return res;
   endfunction

   logic [PARITY_WIDTH-1:0] w_in_syn;
   logic                    w_src_vld;
   logic [DATA_WIDTH-1:0]   w_src_data;
   logic [PARITY_WIDTH-1:0] w_src_syn;
   dec_t                    w_dec;
   logic                    w_out_adv;
   logic                    w_acc;

   logic                    r_out_valid;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [PARITY_WIDTH-1:0] r_out_syn;
   logic                    r_out_sbit;
   logic                    r_out_dbit;
   logic [CNT_WIDTH-1:0]    r_cnt_sbit;
   logic [CNT_WIDTH-1:0]    r_cnt_dbit;
   logic                    r_first_vld;
   logic [PARITY_WIDTH-1:0] r_first_syn;

   assign enc_parity = calc_parity(enc_data);

   // A bypassed beat carries a zero syndrome, which decodes as "no error":
   // data passes untouched and neither flags nor counters react.
   always_comb begin
      // NOTE: default assigned first so no path through the block can infer a latch.
      w_in_syn = '0;
      if (!in_bypass) w_in_syn = in_parity ^ calc_parity(in_data);
   end

   always_comb begin
      w_dec = decode(w_src_data, w_src_syn);
   end

   assign w_out_adv = !r_out_valid || out_ready;

   generate
      if (PIPE_STAGES == 1) begin : g_one
         assign in_ready   = w_out_adv;
         assign w_src_vld  = in_valid;
         assign w_src_data = in_data;
         assign w_src_syn  = w_in_syn;
      end else begin : g_two
         logic                    r_s1_vld;
         logic [DATA_WIDTH-1:0]   r_s1_data;
         logic [PARITY_WIDTH-1:0] r_s1_syn;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1_vld  <= 1'b0;
               r_s1_data <= '0;
               r_s1_syn  <= '0;
            end else if (in_ready) begin
               r_s1_vld <= in_valid;
               if (in_valid) begin
                  r_s1_data <= in_data;
                  r_s1_syn  <= w_in_syn;
               end
            end
         end

         assign in_ready   = !r_s1_vld || w_out_adv;
         assign w_src_vld  = r_s1_vld;
         assign w_src_data = r_s1_data;
         assign w_src_syn  = r_s1_syn;
      end
   endgenerate

   // Output stage only loads when it advances, so a stalled beat holds every out_*.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_syn   <= '0;
         r_out_sbit  <= 1'b0;
         r_out_dbit  <= 1'b0;
      end else if (w_out_adv) begin
         r_out_valid <= w_src_vld;
         if (w_src_vld) begin
            r_out_data <= w_dec.data;
            r_out_syn  <= w_src_syn;
            r_out_sbit <= w_dec.sbit;
            r_out_dbit <= w_dec.dbit;
         end
      end
   end

   assign w_acc = r_out_valid && out_ready;

   // clr_cnt takes priority over a beat leaving in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_sbit  <= '0;
         r_cnt_dbit  <= '0;
         r_first_vld <= 1'b0;
         r_first_syn <= '0;
      end else if (clr_cnt) begin
         r_cnt_sbit  <= '0;
         r_cnt_dbit  <= '0;
         r_first_vld <= 1'b0;
         r_first_syn <= '0;
      end else if (w_acc) begin
         if (r_out_sbit && r_cnt_sbit != CNT_MAX) r_cnt_sbit <= r_cnt_sbit + CNT_WIDTH'(1);
         if (r_out_dbit && r_cnt_dbit != CNT_MAX) r_cnt_dbit <= r_cnt_dbit + CNT_WIDTH'(1);
         if ((r_out_sbit || r_out_dbit) && !r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_syn <= r_out_syn;
         end
      end
   end

   assign out_valid     = r_out_valid;
   assign out_data      = r_out_data;
   assign out_syndrome  = r_out_syn;
   assign out_sbit_err  = r_out_sbit;
   assign out_dbit_err  = r_out_dbit;
   assign cnt_sbit      = r_cnt_sbit;
   assign cnt_dbit      = r_cnt_dbit;
   assign first_err_vld = r_first_vld;
   assign first_err_syn = r_first_syn;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// ---------------------------------------------------------------------------
// tb_ecc_secded_pipe
// Directed bench for ecc_secded_pipe at DATA_WIDTH=13 (PARITY_WIDTH=6),
// PIPE_STAGES=2, CNT_WIDTH=16. Expected parities and syndromes are
// hand-derived from the column list 3,5,6,7,9,10,11,12,13,14,15,17,18.
// ---------------------------------------------------------------------------
module tb_ecc_secded_pipe;

   localparam int DW   = 13;
   localparam int PW   = 6;
   localparam int CW   = 16;
   localparam int PIPE = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] enc_data;
   logic [PW-1:0] enc_parity;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [PW-1:0] in_parity;
   logic          in_bypass;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [PW-1:0] out_syndrome;
   logic          out_sbit_err;
   logic          out_dbit_err;
   logic          clr_cnt;
   logic [CW-1:0] cnt_sbit;
   logic [CW-1:0] cnt_dbit;
   logic          first_err_vld;
   logic [PW-1:0] first_err_syn;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] bp_d [5] = '{13'h0A5A, 13'h0001, 13'h1000, 13'h1FFF, 13'h0555};
   logic [PW-1:0] bp_p [5] = '{6'h3F, 6'h23, 6'h32, 6'h2C, 6'h05};

   ecc_secded_pipe #(
      .DATA_WIDTH  (DW),
      .PIPE_STAGES (PIPE),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enc_data      (enc_data),
      .enc_parity    (enc_parity),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_parity     (in_parity),
      .in_bypass     (in_bypass),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_syndrome  (out_syndrome),
      .out_sbit_err  (out_sbit_err),
      .out_dbit_err  (out_dbit_err),
      .clr_cnt       (clr_cnt),
      .cnt_sbit      (cnt_sbit),
      .cnt_dbit      (cnt_dbit),
      .first_err_vld (first_err_vld),
      .first_err_syn (first_err_syn)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input logic [CW-1:0] xs, input logic [CW-1:0] xd);
      check({tag, " cnt_sbit"}, 64'(cnt_sbit), 64'(xs));
      check({tag, " cnt_dbit"}, 64'(cnt_dbit), 64'(xd));
   endtask

   // Sends one beat into an empty pipe, checks latency and the output beat,
   // and lets it leave (clr_cnt optionally high in the leaving cycle).
   task automatic run_beat(input string tag, input logic [DW-1:0] d, input logic [PW-1:0] p,
                           input logic byp, input logic [DW-1:0] x_data, input logic [PW-1:0] x_syn,
                           input logic x_s, input logic x_d, input logic clr);
      int lat;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_parity = p;
      in_bypass = byp;
      @(negedge clk);
      in_valid  = 1'b0;
      in_bypass = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(PIPE));
      check({tag, " data"}, 64'(out_data), 64'(x_data));
      check({tag, " syndrome"}, 64'(out_syndrome), 64'(x_syn));
      check({tag, " sbit"}, 64'(out_sbit_err), 64'(x_s));
      check({tag, " dbit"}, 64'(out_dbit_err), 64'(x_d));
      clr_cnt = clr;
      @(negedge clk);
      clr_cnt = 1'b0;
      #1;
   endtask

   initial begin
      int            n_in;
      int            n_out;
      logic          stalled;
      logic          saw_block;
      logic [DW-1:0] held_data;

      rst_n     = 1'b0;
      enc_data  = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_parity = '0;
      in_bypass = 1'b0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;

      // Reset state
      #12;
      check("rst out_valid", 64'(out_valid), 64'(1'b0));
      check("rst out_data", 64'(out_data), 64'(13'h0));
      check_cnt("rst", 16'h0, 16'h0);
      check("rst first_vld", 64'(first_err_vld), 64'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst in_ready", 64'(in_ready), 64'(1'b1));

      // Encoder
      enc_data = 13'h0A5A; #1; check("enc 0A5A", 64'(enc_parity), 64'(6'h3F));
      enc_data = 13'h0001; #1; check("enc 0001", 64'(enc_parity), 64'(6'h23));
      enc_data = 13'h1000; #1; check("enc 1000", 64'(enc_parity), 64'(6'h32));
      enc_data = 13'h1FFF; #1; check("enc 1FFF", 64'(enc_parity), 64'(6'h2C));
      enc_data = 13'h0555; #1; check("enc 0555", 64'(enc_parity), 64'(6'h05));

      // Clean beat
      run_beat("clean", 13'h0A5A, 6'h3F, 1'b0, 13'h0A5A, 6'h00, 1'b0, 1'b0, 1'b0);
      check_cnt("clean", 16'd0, 16'd0);
      check("clean first_vld", 64'(first_err_vld), 64'(1'b0));

      // Single data-bit errors (bit 5, lowest bit, highest bit)
      run_beat("bit5", 13'h0A7A, 6'h3F, 1'b0, 13'h0A5A, 6'h2A, 1'b1, 1'b0, 1'b0);
      check_cnt("bit5", 16'd1, 16'd0);
      check("bit5 first_vld", 64'(first_err_vld), 64'(1'b1));
      check("bit5 first_syn", 64'(first_err_syn), 64'(6'h2A));
      run_beat("bit0", 13'h0A5B, 6'h3F, 1'b0, 13'h0A5A, 6'h23, 1'b1, 1'b0, 1'b0);
      run_beat("bit12", 13'h1A5A, 6'h3F, 1'b0, 13'h0A5A, 6'h32, 1'b1, 1'b0, 1'b0);
      check_cnt("bit12", 16'd3, 16'd0);

      // Check-bit errors: O=1 with L zero or a power of two
      run_beat("par5", 13'h0A5A, 6'h1F, 1'b0, 13'h0A5A, 6'h20, 1'b1, 1'b0, 1'b0);
      run_beat("par5+0", 13'h0A5A, 6'h1E, 1'b0, 13'h0A5A, 6'h21, 1'b1, 1'b0, 1'b0);
      check_cnt("par", 16'd5, 16'd0);

      // Double errors: O=0 with L!=0, and O=1 with L=19 (no such column)
      run_beat("dbl01", 13'h0A59, 6'h3F, 1'b0, 13'h0A59, 6'h06, 1'b0, 1'b1, 1'b0);
      check_cnt("dbl01", 16'd5, 16'd1);
      run_beat("nocol", 13'h0A5A, 6'h0C, 1'b0, 13'h0A5A, 6'h33, 1'b0, 1'b1, 1'b0);
      check_cnt("nocol", 16'd5, 16'd2);
      check("dbl first_syn", 64'(first_err_syn), 64'(6'h2A));

      // Bypass of a corrupted word
      run_beat("bypass", 13'h0A7A, 6'h3F, 1'b1, 13'h0A7A, 6'h00, 1'b0, 1'b0, 1'b0);
      check_cnt("bypass", 16'd5, 16'd2);

      // Backpressure: 5 back-to-back clean beats, out_ready low in cycles 2-4
      n_in      = 0;
      n_out     = 0;
      stalled   = 1'b0;
      saw_block = 1'b0;
      held_data = '0;
      for (int c = 0; c < 40 && n_out < 5; c++) begin
         @(negedge clk);
         out_ready = !(c >= 2 && c <= 4);
         in_valid  = (n_in < 5);
         if (n_in < 5) begin
            in_data   = bp_d[n_in];
            in_parity = bp_p[n_in];
         end
         #1;
         if (stalled) begin
            check("bp stall data", 64'(out_data), 64'(held_data));
            check("bp stall valid", 64'(out_valid), 64'(1'b1));
         end
         if (in_valid && !in_ready) saw_block = 1'b1;
         if (out_valid && out_ready) begin
            check("bp data", 64'(out_data), 64'(bp_d[n_out]));
            check("bp syndrome", 64'(out_syndrome), 64'(6'h00));
            n_out++;
         end
         stalled   = out_valid && !out_ready;
         held_data = out_data;
         if (in_valid && in_ready) n_in++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp delivered", 64'(n_out), 64'(5));
      check("bp in_ready dropped", 64'(saw_block), 64'(1'b1));
      check("bp drained", 64'(out_valid), 64'(1'b0));
      check_cnt("bp", 16'd5, 16'd2);

      // Saturation of cnt_sbit
      @(negedge clk);
      force dut.r_cnt_sbit = 16'hFFFF;
      @(negedge clk);
      release dut.r_cnt_sbit;
      #1;
      check("sat preload", 64'(cnt_sbit), 64'(16'hFFFF));
      run_beat("sat", 13'h0A7A, 6'h3F, 1'b0, 13'h0A5A, 6'h2A, 1'b1, 1'b0, 1'b0);
      check_cnt("sat", 16'hFFFF, 16'd2);

      // clr_cnt coincident with an error beat leaving
      run_beat("clr", 13'h0A59, 6'h3F, 1'b0, 13'h0A59, 6'h06, 1'b0, 1'b1, 1'b1);
      check_cnt("clr", 16'd0, 16'd0);
      check("clr first_vld", 64'(first_err_vld), 64'(1'b0));
      check("clr first_syn", 64'(first_err_syn), 64'(6'h00));

      // Reset with two beats in flight
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 13'h0001;
      in_parity = 6'h23;
      @(negedge clk);
      in_data   = 13'h1000;
      in_parity = 6'h32;
      @(negedge clk);
      in_valid  = 1'b0;
      #1;
      check("mid pre out_valid", 64'(out_valid), 64'(1'b1));
      rst_n = 1'b0;
      #1;
      check("mid rst out_valid", 64'(out_valid), 64'(1'b0));
      check("mid rst out_data", 64'(out_data), 64'(13'h0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid rel in_ready", 64'(in_ready), 64'(1'b1));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mid no stale beat", 64'(out_valid), 64'(1'b0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
